// File: rtl/gray_count_decoder.sv
`default_nettype none
// ============================================================================
// Module   : gray_count_decoder
// Purpose  : Synchronises a Gray-coded count into clk and decodes it to binary.
//            It also flags legal single steps and counts illegal transitions.
//            Define GRAY_DEC_BIDIR_EN to accept backward single steps as legal.
// Revision : 1.0 - initial release
// ============================================================================
module gray_count_decoder #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] gray_in,
    input  logic         err_clr,
    output logic [N-1:0] bin_count,
    output logic         bin_valid,
    output logic         step,
    output logic         err,
    output logic [7:0]   err_count
);

`ifdef GRAY_DEC_BIDIR_EN
    localparam bit C_BIDIR = 1'b1;
`else
    localparam bit C_BIDIR = 1'b0;
`endif

    localparam int FILL_W = $clog2(SYNC_STAGES) + 1;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_PRIME = 2'd1,
        S_TRACK = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [N-1:0]        sync_q [SYNC_STAGES];
    logic [N-1:0]        prev_gray_q, prev_gray_d;
    logic [N-1:0]        bin_count_q, bin_count_d;
    logic                bin_valid_q, bin_valid_d;
    logic                step_q, step_d;
    logic                err_q, err_d;
    logic [7:0]          err_count_q, err_count_d;

    logic [N-1:0]        g_s;
    logic [N-1:0]        b;
    logic [N-1:0]        diff;
    logic                single_bit;
    logic                fwd;
    logic                bwd;
    logic                illegal;

    generate
        for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
            if (i == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_q[i] <= '0;
                    else     sync_q[i] <= gray_in;
                end
            end else begin : g_rest
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_q[i] <= '0;
                    else     sync_q[i] <= sync_q[i-1];
                end
            end
        end
    endgenerate

    assign g_s = sync_q[SYNC_STAGES-1];

    // MSB passes through; each lower bit folds in the running XOR from above.
    always_comb begin
        b[N-1] = g_s[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g_s[i];
        end
    end

    assign diff       = g_s ^ prev_gray_q;
    assign single_bit = (diff != '0) && ((diff & (diff - N'(1))) == '0);
    assign fwd        = (b == bin_count_q + N'(1));
    assign bwd        = (b == bin_count_q - N'(1));

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        prev_gray_d = prev_gray_q;
        bin_count_d = bin_count_q;
        bin_valid_d = bin_valid_q;
        step_d      = 1'b0;
        illegal     = 1'b0;

        case (state_q)
            S_FILL: begin
                fill_cnt_d = fill_cnt_q + FILL_W'(1);
                if (fill_cnt_q == FILL_W'(SYNC_STAGES - 1)) begin
                    state_d = S_PRIME;
                end
            end
            S_PRIME: begin
                bin_count_d = b;
                prev_gray_d = g_s;
                bin_valid_d = 1'b1;
                state_d     = S_TRACK;
            end
            S_TRACK: begin
                if (diff != '0) begin
                    // Resync to the sampled value whether or not the move was legal.
                    bin_count_d = b;
                    prev_gray_d = g_s;
                    if (single_bit && (fwd || (C_BIDIR && bwd))) begin
                        step_d = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase

        err_d       = err_q;
        err_count_d = err_count_q;
        if (err_clr) begin
            err_d       = 1'b0;
            err_count_d = 8'd0;
        end
        if (illegal) begin
            err_d = 1'b1;
            if (err_clr) begin
                err_count_d = 8'd1;
            end else if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FILL;
            fill_cnt_q  <= '0;
            prev_gray_q <= '0;
            bin_count_q <= '0;
            bin_valid_q <= 1'b0;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            prev_gray_q <= prev_gray_d;
            bin_count_q <= bin_count_d;
            bin_valid_q <= bin_valid_d;
            step_q      <= step_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bin_count = bin_count_q;
    assign bin_valid = bin_valid_q;
    assign step      = step_q;
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_count_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_count_decoder
// Purpose  : Randomised and directed self-checking bench for gray_count_decoder
//            against a table-driven behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_count_decoder;

    localparam int N  = 4;
    localparam int SS = 2;
    localparam int M  = 1 << N;
`ifdef GRAY_DEC_BIDIR_EN
    localparam bit BIDIR = 1'b1;
`else
    localparam bit BIDIR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] gray_in;
    logic         err_clr;
    logic [N-1:0] bin_count;
    logic         bin_valid;
    logic         step;
    logic         err;
    logic [7:0]   err_count;

    gray_count_decoder #(.N(N), .SYNC_STAGES(SS)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .gray_in   (gray_in),
        .err_clr   (err_clr),
        .bin_count (bin_count),
        .bin_valid (bin_valid),
        .step      (step),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int step_seen = 0;

    int g2b [M];
    int b2g [M];

    // Reference model state
    int m_q[$];
    int m_edges;
    int m_bin, m_prev, m_valid, m_step, m_err, m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_q = {};
        for (int i = 0; i < SS; i++) m_q.push_back(0);
        m_edges = 0;
        m_bin = 0; m_prev = 0; m_valid = 0; m_step = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic m_edge();
        int gs, nb, bad;
        gs = m_q.pop_front();
        m_q.push_back(int'(gray_in));
        m_step = 0;
        bad = 0;
        if (m_edges < SS) begin
            m_edges++;
        end else if (m_edges == SS) begin
            m_bin = g2b[gs]; m_prev = gs; m_valid = 1;
            m_edges++;
        end else if (gs != m_prev) begin
            nb = g2b[gs];
            if ($countones(gs ^ m_prev) == 1 &&
                (nb == (m_bin + 1) % M || (BIDIR && nb == (m_bin + M - 1) % M)))
                m_step = 1;
            else
                bad = 1;
            m_bin = nb; m_prev = gs;
        end
        if (err_clr) begin m_err = 0; m_cnt = 0; end
        if (bad) begin
            m_err = 1;
            m_cnt = err_clr ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
        end
    endtask

    task automatic check_outputs();
        chk("bin_count", 32'(bin_count), 32'(m_bin));
        chk("bin_valid", 32'(bin_valid), 32'(m_valid));
        chk("step",      32'(step),      32'(m_step));
        chk("err",       32'(err),       32'(m_err));
        chk("err_count", 32'(err_count), 32'(m_cnt));
        if (step === 1'b1) step_seen++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) m_reset(); else m_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic drive_bin(input int bv, input int n);
        gray_in = N'(b2g[bv % M]);
        hold(n);
    endtask

    task automatic clear_err();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
    endtask

    // Reset raised between clock edges; outputs must clear with no edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1 m_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int v = 0; v < M; v++) begin
            b2g[v] = v ^ (v >> 1);
            g2b[v ^ (v >> 1)] = v;
        end
        m_reset();
        rst = 1'b1; gray_in = 4'b0110; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // Priming latency with gray 0110 held
        hold(2);
        chk("t1_valid_early", 32'(bin_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(bin_valid), 32'd1);
        chk("t1_bin", 32'(bin_count), 32'd4);
        chk("t1_err", 32'(err), 32'd0);

        // Full forward walk including wrap
        drive_bin(0, 4);
        clear_err();
        step_seen = 0;
        for (int v = 1; v <= M; v++) drive_bin(v, 4);
        chk("t2_steps", 32'(step_seen), 32'd16);
        chk("t2_bin", 32'(bin_count), 32'd0);
        chk("t2_err", 32'(err), 32'd0);

        // Illegal jump 1 -> 5
        drive_bin(1, 4);
        clear_err();
        drive_bin(5, 3);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_cnt", 32'(err_count), 32'd1);
        chk("t3_bin", 32'(bin_count), 32'd5);
        hold(2);

        // Backward step 2 -> 1
        drive_bin(2, 4);
        clear_err();
        drive_bin(1, 3);
        chk("t4_bin", 32'(bin_count), 32'd1);
        chk("t4_step", 32'(step), BIDIR ? 32'd1 : 32'd0);
        chk("t4_err", 32'(err), BIDIR ? 32'd0 : 32'd1);
        hold(2);

        // Error clear colliding with a new illegal jump
        clear_err();
        drive_bin(6, 4); drive_bin(0, 4); drive_bin(6, 4);
        chk("t5_cnt3", 32'(err_count), 32'd3);
        gray_in = N'(b2g[0]);
        hold(2);
        clear_err();
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_cnt", 32'(err_count), 32'd1);
        hold(2);
        clear_err();
        chk("t5_err_clr", 32'(err), 32'd0);
        chk("t5_cnt_clr", 32'(err_count), 32'd0);

        // Saturation, then asynchronous reset at bin 9
        for (int k = 0; k < 300; k++) drive_bin((k % 2) ? 0 : 2, 3);
        drive_bin(9, 4);
        chk("t6_sat", 32'(err_count), 32'd255);
        chk("t6_bin", 32'(bin_count), 32'd9);
        async_reset();
        hold(2);
        chk("t6_valid_early", 32'(bin_valid), 32'd0);
        tick();
        chk("t6_valid", 32'(bin_valid), 32'd1);
        chk("t6_err", 32'(err), 32'd0);

        // Randomised traffic
        begin
            int cur, r;
            cur = 9;
            for (int k = 0; k < 600; k++) begin
                r = $urandom_range(0, 99);
                if (r < 45)      cur = (cur + 1) % M;
                else if (r < 55) cur = (cur + M - 1) % M;
                else if (r < 65) cur = $urandom_range(0, M - 1);
                gray_in = N'(b2g[cur]);
                err_clr = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 149) == 0) async_reset();
                else tick();
            end
            err_clr = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_count_decoder.md
Name: gray_count_decoder

Overview:
Receiving end of a Gray-coded count bus, such as the output of a Gray counter running in another clock domain. The block synchronises the Gray word into clk, converts it back to binary and registers the result. It tracks successive samples, reports legal single steps, and flags illegal multi-bit transitions. Typical uses are the read side of async FIFO pointers and encoder and position counters.

Parameters:
N, 4, width of the Gray/binary count (N >= 2)
SYNC_STAGES, 2, number of synchroniser flops on gray_in (>= 2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
gray_in  input  N  Gray-coded count, may be asynchronous to clk
err_clr  input  1  synchronous clear of err and err_count
bin_count  output  N  decoded binary count, registered
bin_valid  output  1  bin_count holds a real decoded sample
step  output  1  one-cycle pulse: legal single-count change loaded this cycle
err  output  1  sticky: an illegal transition has been seen
err_count  output  8  number of illegal transitions, saturating at 255

Behaviour:
- Reset is asynchronous, active-high, on clk domain. While rst is high, all of the following are 0: sync flops, prev_gray, bin_count, bin_valid, step, err, err_count. FSM goes to S_FILL.
- Synchroniser: SYNC_STAGES-deep flop chain on gray_in. Its output is g_s.
- Decode (combinational on g_s): b[N-1] = g_s[N-1]; b[i] = b[i+1] ^ g_s[i], for i from N-2 down to 0.
- Latency: a change on gray_in reaches bin_count after SYNC_STAGES+1 rising edges.
- FSM states: S_FILL, S_PRIME, S_TRACK.
- S_FILL:
  - A fill counter counts SYNC_STAGES edges after reset release; outputs are held.
  - This flushes the reset zeros out of the chain.
  - Go to S_PRIME when fill_cnt = SYNC_STAGES-1.
- S_PRIME (one cycle):
  - Load bin_count <= b and prev_gray <= g_s; set bin_valid <= 1.
  - step = 0; no error check.
  - Go to S_TRACK.
- S_TRACK (every edge, compare g_s with prev_gray; d = popcount(g_s ^ prev_gray)):
  - d = 0: hold bin_count; step = 0.
  - d = 1 and b == bin_count+1 mod 2^N: load b; step = 1. The wrap from max to 0 is legal (N=4: gray 1000 -> 0000 gives bin 15 -> 0).
  - d = 1 and b == bin_count-1 mod 2^N (backward): handled per the Optional Feature.
  - d > 1: illegal. Load b anyway (resync); step = 0; err <= 1; err_count += 1, saturating at 255.
  - prev_gray <= g_s on every load.
- bin_valid stays 1 until the next rst.
- step is high for exactly one cycle per legal change and is never high in the same cycle as an error.
- err_clr:
  - When high, the next edge sets err <= 0 and err_count <= 0.
  - If an illegal transition is detected on the same edge, the error wins: err = 1 and err_count = 1.
  - err_clr has no effect on bin_count or the FSM.
- rst mid-operation: outputs clear immediately (asynchronous). After release the full S_FILL/S_PRIME sequence repeats, and no step or error is generated against the pre-reset value.
- No X on outputs after reset, regardless of gray_in.

Optional Feature:
Macro GRAY_DEC_BIDIR_EN.
- Defined: a backward single step (d = 1, b == bin_count-1 mod 2^N) is legal. bin_count loads b, step pulses for 1 cycle, no error. This supports up/down Gray counters.
- Not defined: a backward step is treated as illegal. Load b, step = 0, err <= 1, err_count increments.

Test Plan:
1. N=4, SYNC_STAGES=2. Hold gray_in=0110, pulse rst, release. Required: bin_valid=0 through edges 1-2; after edge 3, bin_valid=1, bin_count=4, step=0, err=0.
2. From gray 0000, step gray_in through all 16 codes every 4 cycles, ending with 1000 -> 0000. Required: bin_count 0..15 then 0; exactly 16 single-cycle step pulses; err=0.
3. Settle at 0001 (bin 1), then drive 0111 (bin 5). Required: bin_count=5, step=0, err=1, err_count=1.
4. Settle at 0011 (bin 2), then drive 0001 (bin 1).
   - Macro undefined: err=1, err_count increments, step=0, bin_count=1.
   - Macro defined: step=1, err=0, bin_count=1.
5. Hold err=1, err_count=3. Assert err_clr on the same edge a new illegal jump is sampled. Required: err=1, err_count=1. Next err_clr with no error: err=0, err_count=0.
6. Force 300 illegal jumps, then assert rst asynchronously mid-cycle at bin_count=9. Required: err_count saturated at 255 before reset. At reset, all outputs go to 0 without waiting for a clk edge, and the priming sequence of test 1 repeats.
